// File: rtl/reservation_station_pkg.sv
// Shared widths, sizes and ALU op encodings for the ALU reservation station.
// The op encodings are common to the RS and the ALU.
package reservation_station_pkg;

  localparam int OP_LOG  = 5;
  localparam int ROB_LOG = 4;
  localparam int RS_SIZE = 16;
  localparam int RS_LOG  = 4;

  localparam logic [OP_LOG-1:0] OP_NOP = 5'd0;
  localparam logic [OP_LOG-1:0] OP_ADD = 5'd1;
  localparam logic [OP_LOG-1:0] OP_SUB = 5'd2;
  localparam logic [OP_LOG-1:0] OP_XOR = 5'd3;
  localparam logic [OP_LOG-1:0] OP_OR  = 5'd4;
  localparam logic [OP_LOG-1:0] OP_AND = 5'd5;
  localparam logic [OP_LOG-1:0] OP_BEQ = 5'd6;
  localparam logic [OP_LOG-1:0] OP_JAL = 5'd7;

endpackage

// File: rtl/reservation_station_rs_pick.sv
// Lowest-index priority encoder: returns the index of the lowest set request
// bit and whether any bit was set.
module rs_pick #(
  parameter int N   = 16,
  parameter int LOG = 4
) (
  input  logic [N-1:0]   req,
  output logic [LOG-1:0] idx,
  output logic           found
);

  always_comb begin
    idx   = '0;
    found = |req;
    // scan downwards so the lowest set bit is the last one written
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = LOG'(i);
    end
  end

endmodule

// File: rtl/reservation_station.sv
// ALU reservation station: holds issued instructions until both operands are
// available, snoops the result buses, and dispatches one ready entry per cycle.
module reservation_station
  import reservation_station_pkg::*;
#(
  parameter int RS_SIZE = reservation_station_pkg::RS_SIZE,
  parameter int RS_LOG  = reservation_station_pkg::RS_LOG
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               rdy,
  input  logic               clear,
  input  logic               D_enable,
  input  logic [OP_LOG-1:0]  D_op,
  input  logic [31:0]        D_Vj,
  input  logic [31:0]        D_Vk,
  input  logic               D_Qj_busy,
  input  logic               D_Qk_busy,
  input  logic [ROB_LOG-1:0] D_Qj,
  input  logic [ROB_LOG-1:0] D_Qk,
  input  logic [31:0]        D_Imm,
  input  logic [ROB_LOG-1:0] D_DestRob,
  input  logic [31:0]        D_CurPC,
  output logic               RS_full,
  input  logic               B_enable,
  input  logic [31:0]        B_value,
  input  logic [ROB_LOG-1:0] B_RobId,
  input  logic               L_enable,
  input  logic [31:0]        L_value,
  input  logic [ROB_LOG-1:0] L_RobId,
  output logic               RS_valid,
  output logic [OP_LOG-1:0]  RS_op,
  output logic [31:0]        RS_Vj,
  output logic [31:0]        RS_Vk,
  output logic [31:0]        RS_Imm,
  output logic [31:0]        RS_CurPC,
  output logic [ROB_LOG-1:0] RS_DestRob
);

  logic [RS_SIZE-1:0] busy;
  logic [RS_SIZE-1:0] qj_busy;
  logic [RS_SIZE-1:0] qk_busy;
  logic [OP_LOG-1:0]  op   [RS_SIZE];
  logic [31:0]        vj   [RS_SIZE];
  logic [31:0]        vk   [RS_SIZE];
  logic [ROB_LOG-1:0] qj   [RS_SIZE];
  logic [ROB_LOG-1:0] qk   [RS_SIZE];
  logic [31:0]        imm  [RS_SIZE];
  logic [ROB_LOG-1:0] dest [RS_SIZE];
  logic [31:0]        pc   [RS_SIZE];

  logic [RS_LOG-1:0]  free_idx;
  logic               free_found;
  logic [RS_LOG-1:0]  ready_idx;
  logic               ready_found;
  logic               issue;

  logic [31:0]        iss_vj;
  logic [31:0]        iss_vk;
  logic               iss_qj_busy;
  logic               iss_qk_busy;

  rs_pick #(.N(RS_SIZE), .LOG(RS_LOG)) u_free_pick (
    .req   (~busy),
    .idx   (free_idx),
    .found (free_found)
  );

  rs_pick #(.N(RS_SIZE), .LOG(RS_LOG)) u_ready_pick (
    .req   (busy & ~qj_busy & ~qk_busy),
    .idx   (ready_idx),
    .found (ready_found)
  );

  assign RS_full = &busy;
  assign issue   = D_enable && free_found;

  // Operand bypass: a tag resolving on a bus in the issue cycle would
  // otherwise be missed forever, since the entry does not exist yet.
  always_comb begin
    iss_vj      = D_Vj;
    iss_qj_busy = D_Qj_busy;
    iss_vk      = D_Vk;
    iss_qk_busy = D_Qk_busy;
    if (D_Qj_busy && B_enable && (D_Qj == B_RobId)) begin
      iss_vj      = B_value;
      iss_qj_busy = 1'b0;
    end else if (D_Qj_busy && L_enable && (D_Qj == L_RobId)) begin
      iss_vj      = L_value;
      iss_qj_busy = 1'b0;
    end
    if (D_Qk_busy && B_enable && (D_Qk == B_RobId)) begin
      iss_vk      = B_value;
      iss_qk_busy = 1'b0;
    end else if (D_Qk_busy && L_enable && (D_Qk == L_RobId)) begin
      iss_vk      = L_value;
      iss_qk_busy = 1'b0;
    end
  end

  // Issue writes last so it wins over stale wake-up on a free slot; the
  // issued slot is free pre-edge and therefore never the dispatched one.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy    <= '0;
      qj_busy <= '0;
      qk_busy <= '0;
    end else if (rdy) begin
      if (clear) begin
        busy <= '0;
      end else begin
        for (int i = 0; i < RS_SIZE; i++) begin
          if (qj_busy[i] && B_enable && (qj[i] == B_RobId)) begin
            vj[i]      <= B_value;
            qj_busy[i] <= 1'b0;
          end else if (qj_busy[i] && L_enable && (qj[i] == L_RobId)) begin
            vj[i]      <= L_value;
            qj_busy[i] <= 1'b0;
          end
          if (qk_busy[i] && B_enable && (qk[i] == B_RobId)) begin
            vk[i]      <= B_value;
            qk_busy[i] <= 1'b0;
          end else if (qk_busy[i] && L_enable && (qk[i] == L_RobId)) begin
            vk[i]      <= L_value;
            qk_busy[i] <= 1'b0;
          end
        end
        if (ready_found) busy[ready_idx] <= 1'b0;
        if (issue) begin
          busy[free_idx]    <= 1'b1;
          op[free_idx]      <= D_op;
          vj[free_idx]      <= iss_vj;
          vk[free_idx]      <= iss_vk;
          qj_busy[free_idx] <= iss_qj_busy;
          qk_busy[free_idx] <= iss_qk_busy;
          qj[free_idx]      <= D_Qj;
          qk[free_idx]      <= D_Qk;
          imm[free_idx]     <= D_Imm;
          dest[free_idx]    <= D_DestRob;
          pc[free_idx]      <= D_CurPC;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      RS_valid   <= 1'b0;
      RS_op      <= OP_NOP;
      RS_Vj      <= '0;
      RS_Vk      <= '0;
      RS_Imm     <= '0;
      RS_CurPC   <= '0;
      RS_DestRob <= '0;
    end else if (rdy) begin
      if (clear) begin
        RS_valid <= 1'b0;
      end else begin
        RS_valid <= ready_found;
        if (ready_found) begin
          RS_op      <= op[ready_idx];
          RS_Vj      <= vj[ready_idx];
          RS_Vk      <= vk[ready_idx];
          RS_Imm     <= imm[ready_idx];
          RS_CurPC   <= pc[ready_idx];
          RS_DestRob <= dest[ready_idx];
        end
      end
    end
  end

endmodule

// File: tb/tb_reservation_station.sv
// Directed bench for reservation_station: reset, issue, wake-up, bypass,
// full/drop, flush and ordering under rdy stalls.
module tb_reservation_station;
  import reservation_station_pkg::*;

  logic               clk = 1'b0;
  logic               rst_n, rdy, clear;
  logic               D_enable;
  logic [OP_LOG-1:0]  D_op;
  logic [31:0]        D_Vj, D_Vk, D_Imm, D_CurPC;
  logic               D_Qj_busy, D_Qk_busy;
  logic [ROB_LOG-1:0] D_Qj, D_Qk, D_DestRob;
  logic               RS_full;
  logic               B_enable, L_enable;
  logic [31:0]        B_value, L_value;
  logic [ROB_LOG-1:0] B_RobId, L_RobId;
  logic               RS_valid;
  logic [OP_LOG-1:0]  RS_op;
  logic [31:0]        RS_Vj, RS_Vk, RS_Imm, RS_CurPC;
  logic [ROB_LOG-1:0] RS_DestRob;

  int total = 0;
  int bad   = 0;

  reservation_station dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .clear(clear),
    .D_enable(D_enable), .D_op(D_op), .D_Vj(D_Vj), .D_Vk(D_Vk),
    .D_Qj_busy(D_Qj_busy), .D_Qk_busy(D_Qk_busy), .D_Qj(D_Qj), .D_Qk(D_Qk),
    .D_Imm(D_Imm), .D_DestRob(D_DestRob), .D_CurPC(D_CurPC),
    .RS_full(RS_full),
    .B_enable(B_enable), .B_value(B_value), .B_RobId(B_RobId),
    .L_enable(L_enable), .L_value(L_value), .L_RobId(L_RobId),
    .RS_valid(RS_valid), .RS_op(RS_op), .RS_Vj(RS_Vj), .RS_Vk(RS_Vk),
    .RS_Imm(RS_Imm), .RS_CurPC(RS_CurPC), .RS_DestRob(RS_DestRob)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_issue(input logic [OP_LOG-1:0] op, input logic [31:0] vj,
                             input logic [31:0] vk, input logic qjb,
                             input logic [ROB_LOG-1:0] qj, input logic qkb,
                             input logic [ROB_LOG-1:0] qk, input logic [31:0] imm,
                             input logic [ROB_LOG-1:0] dst);
    D_enable = 1'b1; D_op = op; D_Vj = vj; D_Vk = vk;
    D_Qj_busy = qjb; D_Qj = qj; D_Qk_busy = qkb; D_Qk = qk;
    D_Imm = imm; D_DestRob = dst; D_CurPC = 32'h1000 + 32'(dst);
  endtask

  task automatic bus_off();
    D_enable = 1'b0; B_enable = 1'b0; L_enable = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; rdy = 1'b1; clear = 1'b0;
    D_enable = 1'b0; D_op = OP_NOP; D_Vj = '0; D_Vk = '0; D_Imm = '0; D_CurPC = '0;
    D_Qj_busy = 1'b0; D_Qk_busy = 1'b0; D_Qj = '0; D_Qk = '0; D_DestRob = '0;
    B_enable = 1'b0; B_value = '0; B_RobId = '0;
    L_enable = 1'b0; L_value = '0; L_RobId = '0;

    // reset
    tick(); tick();
    check("rst_valid", 32'(RS_valid), 32'd0);
    check("rst_full",  32'(RS_full),  32'd0);
    check("rst_vj",    RS_Vj,         32'd0);
    rst_n = 1'b1;
    tick();

    // plain ready issue: two-cycle latency
    drive_issue(OP_ADD, 32'd3, 32'd4, 1'b0, 4'd0, 1'b0, 4'd0, 32'd0, 4'd5);
    tick(); bus_off();
    check("add_not_yet", 32'(RS_valid), 32'd0);
    tick();
    check("add_valid", 32'(RS_valid), 32'd1);
    check("add_op",    32'(RS_op),    32'(OP_ADD));
    check("add_vj",    RS_Vj,         32'd3);
    check("add_vk",    RS_Vk,         32'd4);
    check("add_dest",  32'(RS_DestRob), 32'd5);
    check("add_pc",    RS_CurPC,      32'h1005);
    tick();
    check("add_once",  32'(RS_valid), 32'd0);
    check("add_hold",  RS_Vj,         32'd3);

    // wake-up via ALU bus
    drive_issue(OP_SUB, 32'd0, 32'd10, 1'b1, 4'd7, 1'b0, 4'd0, 32'd0, 4'd1);
    tick(); bus_off();
    tick();
    check("sub_wait", 32'(RS_valid), 32'd0);
    B_enable = 1'b1; B_RobId = 4'd7; B_value = 32'd25;
    tick(); bus_off();
    check("sub_wake_edge", 32'(RS_valid), 32'd0);
    tick();
    check("sub_valid", 32'(RS_valid), 32'd1);
    check("sub_op",    32'(RS_op),    32'(OP_SUB));
    check("sub_vj",    RS_Vj,         32'd25);
    check("sub_vk",    RS_Vk,         32'd10);
    tick();

    // issue-time bypass from load bus
    drive_issue(OP_OR, 32'd1, 32'd0, 1'b0, 4'd0, 1'b1, 4'd2, 32'd0, 4'd3);
    L_enable = 1'b1; L_RobId = 4'd2; L_value = 32'hDEAD;
    tick(); bus_off();
    tick();
    check("byp_valid", 32'(RS_valid), 32'd1);
    check("byp_vk",    RS_Vk,         32'hDEAD);
    check("byp_dest",  32'(RS_DestRob), 32'd3);
    tick();

    // fill all 16 entries with pending operands (entry i waits on tag i)
    for (int i = 0; i < 16; i++) begin
      if (i == 15) check("full_before_last", 32'(RS_full), 32'd0);
      drive_issue(OP_AND, 32'd0, 32'd0, 1'b1, ROB_LOG'(i), 1'b0, 4'd0, 32'd0, ROB_LOG'(i));
      tick();
    end
    bus_off();
    check("full_set", 32'(RS_full), 32'd1);
    drive_issue(OP_XOR, 32'd9, 32'd9, 1'b0, 4'd0, 1'b0, 4'd0, 32'h77, 4'd14);
    tick(); bus_off();
    check("drop_full",  32'(RS_full),  32'd1);
    check("drop_valid", 32'(RS_valid), 32'd0);
    B_enable = 1'b1; B_RobId = 4'd6; B_value = 32'd100;
    tick(); bus_off();
    check("full_wake_edge", 32'(RS_valid), 32'd0);
    tick();
    check("full_disp_valid", 32'(RS_valid), 32'd1);
    check("full_disp_dest",  32'(RS_DestRob), 32'd6);
    check("full_disp_vj",    RS_Vj,         32'd100);
    check("full_cleared",    32'(RS_full),  32'd0);
    tick();
    check("dropped_never", 32'(RS_valid), 32'd0);

    // flush with a ready entry in flight and a simultaneous issue
    B_enable = 1'b1; B_RobId = 4'd0; B_value = 32'd1;
    tick(); bus_off();
    clear = 1'b1;
    drive_issue(OP_ADD, 32'd5, 32'd5, 1'b0, 4'd0, 1'b0, 4'd0, 32'h55, 4'd13);
    tick(); bus_off(); clear = 1'b0;
    check("flush_valid", 32'(RS_valid), 32'd0);
    check("flush_full",  32'(RS_full),  32'd0);
    for (int t = 0; t < 16; t++) begin
      B_enable = 1'b1; B_RobId = ROB_LOG'(t); B_value = 32'(t);
      tick();
      check("flush_no_disp", 32'(RS_valid), 32'd0);
    end
    bus_off();
    tick();

    // ordering: slots 0 and 3 woken together; rdy stall mid-stream
    drive_issue(OP_ADD, 32'd0, 32'd1, 1'b1, 4'd4, 1'b0, 4'd0, 32'd0, 4'd10);
    tick();
    drive_issue(OP_ADD, 32'd0, 32'd1, 1'b1, 4'd12, 1'b0, 4'd0, 32'd0, 4'd11);
    tick();
    drive_issue(OP_ADD, 32'd0, 32'd1, 1'b1, 4'd12, 1'b0, 4'd0, 32'd0, 4'd12);
    tick();
    drive_issue(OP_BEQ, 32'd33, 32'd0, 1'b0, 4'd0, 1'b1, 4'd5, 32'd0, 4'd13);
    tick(); bus_off();
    B_enable = 1'b1; B_RobId = 4'd4; B_value = 32'd44;
    L_enable = 1'b1; L_RobId = 4'd5; L_value = 32'd55;
    tick(); bus_off();
    tick();
    check("ord_first_valid", 32'(RS_valid), 32'd1);
    check("ord_first_dest",  32'(RS_DestRob), 32'd10);
    check("ord_first_vj",    RS_Vj,         32'd44);
    rdy = 1'b0;
    for (int s = 0; s < 3; s++) begin
      tick();
      check("stall_valid", 32'(RS_valid), 32'd1);
      check("stall_dest",  32'(RS_DestRob), 32'd10);
      check("stall_vj",    RS_Vj,         32'd44);
    end
    rdy = 1'b1;
    tick();
    check("ord_second_valid", 32'(RS_valid), 32'd1);
    check("ord_second_dest",  32'(RS_DestRob), 32'd13);
    check("ord_second_op",    32'(RS_op),    32'(OP_BEQ));
    check("ord_second_vj",    RS_Vj,         32'd33);
    check("ord_second_vk",    RS_Vk,         32'd55);
    tick();
    check("ord_done", 32'(RS_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
